// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one word access at a time,
// mem_stall held for LATENCY cycles, then a single DONE cycle with read data and error.
module dmem_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(WORDS);
  // Accept edge plus (CNT_LOAD+1) BUSY cycles gives LATENCY stall cycles in total.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           lat_write;
  logic [AW+1:0]  lat_addr;
  logic [31:0]    lat_data;

  logic [31:0]    mem [WORDS];

  logic           req;
  logic           accept;
  logic           go_done;
  logic           cur_write;
  logic [AW+1:0]  cur_addr;
  logic [31:0]    cur_data;
  logic           cur_misaligned;
  logic [AW-1:0]  cur_idx;
  logic           commit;
  logic           unused_addr_bits;

  assign req    = mem_read | mem_write;
  assign accept = (state == IDLE) && req;

  // With LATENCY==1 the accept edge is also the edge entering DONE, so the live
  // inputs are used there; otherwise the latched copies are.
  assign go_done = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd0));

  assign cur_write      = (state == IDLE) ? mem_write : lat_write;
  assign cur_addr       = (state == IDLE) ? address[AW+1:0] : lat_addr;
  assign cur_data       = (state == IDLE) ? write_data : lat_data;
  assign cur_misaligned = (cur_addr[1:0] != 2'b00);
  assign cur_idx        = cur_addr[AW+1:2];
  assign commit         = go_done && cur_write && !cur_misaligned && !rst;

  assign unused_addr_bits = ^address[31:AW+2];

  assign mem_stall = !rst && (accept || (state == BUSY));
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= 32'd0;
      read_data <= 32'd0;
      mem_err   <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (go_done) begin
        read_data <= (!cur_write && !cur_misaligned) ? mem[cur_idx] : 32'd0;
        mem_err   <= cur_misaligned;
      end
      case (state)
        IDLE: begin
          if (req) begin
            lat_write <= mem_write;
            lat_addr  <= address[AW+1:0];
            lat_data  <= write_data;
            cnt       <= CNT_LOAD;
            state     <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The array has no reset: contents survive rst, only in-flight writes are dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_idx] <= cur_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder: driver tasks push expected
// DONE-cycle results into a queue that an independent monitor pops and checks.
module tb_dmem_responder;

  localparam int WORDS   = 1024;
  localparam int LATENCY = 3;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        mem_err;
  logic [1:0]  dbg_state;

  dmem_responder #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] held_rd = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Returns {mem_err, read_data} for one access and updates the model memory.
  function automatic logic [32:0] model_access(input bit rd, input bit wr,
                                               input logic [31:0] addr, input logic [31:0] data);
    int  idx;
    bit  err;
    logic [31:0] rdata;
    idx   = int'((addr / 4) % WORDS);
    err   = (addr % 4) != 0;
    rdata = 32'd0;
    if (wr) begin
      if (!err) model_mem[idx] = data;
    end else if (rd && !err) begin
      rdata = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
    end
    return {err, rdata};
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble);
    int  stalls;
    bit  done_seen;
    stalls    = 0;
    done_seen = 0;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = data;
    exp_q.push_back(model_access(rd, wr, addr, data));
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!mem_stall) begin
        done_seen = 1;
        break;
      end
      stalls++;
      @(negedge clk);
      if (scramble) begin
        address    = $urandom;
        write_data = $urandom;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("done_reached", 64'(done_seen), 64'd1);
    check("stall_cycles", 64'(stalls), 64'(LATENCY));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_rd = 32'd0;
        check("reset_read_data", 64'(read_data), 64'd0);
        check("reset_mem_err", 64'(mem_err), 64'd0);
      end else if (dbg_state == 2'd2) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("done_read_data", 64'(read_data), 64'(e[31:0]));
          check("done_mem_err", 64'(mem_err), 64'(e[32]));
          check("done_stall_low", 64'(mem_stall), 64'd0);
          held_rd = e[31:0];
        end
      end else begin
        check("read_data_hold", 64'(read_data), 64'(held_rd));
        check("mem_err_idle_low", 64'(mem_err), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          w;
    bit          rd;
    bit          wr;
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 64'(mem_stall), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read latency and data hold
    do_access(0, 1, 32'h10, 32'hDEADBEEF, 0);
    do_access(1, 0, 32'h10, 32'h0, 0);
    // Back-to-back writes then reads
    do_access(0, 1, 32'h0, 32'h11111111, 0);
    do_access(0, 1, 32'h4, 32'h22222222, 0);
    do_access(1, 0, 32'h0, 32'h0, 0);
    do_access(1, 0, 32'h4, 32'h0, 0);
    // Misaligned write must not touch the array
    do_access(0, 1, 32'h22, 32'hFFFFFFFF, 0);
    do_access(1, 0, 32'h20, 32'h0, 0);
    // Address wrap modulo 4*WORDS
    do_access(0, 1, 32'h1000, 32'hA5A5A5A5, 0);
    do_access(1, 0, 32'h0, 32'h0, 0);

    // Reset in the second BUSY cycle of a write aborts it
    @(negedge clk);
    mem_write  = 1'b1;
    address    = 32'h8;
    write_data = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_stall_drop", 64'(mem_stall), 64'd0);
    check("rst_state_idle", 64'(dbg_state), 64'd0);
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_access(1, 0, 32'h8, 32'h0, 0);

    // Simultaneous read and write behaves as a write
    do_access(1, 1, 32'hC, 32'h0000CAFE, 0);
    do_access(1, 0, 32'hC, 32'h0, 0);

    // Randomised accesses over a small, aliased address window
    for (int n = 0; n < 80; n++) begin
      w  = $urandom_range(0, 15);
      a  = 32'(w * 4) + (($urandom_range(0, 1) == 1) ? 32'h1000 * $urandom_range(1, 3) : 32'h0);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      case ($urandom_range(0, 3))
        0:       begin rd = 1; wr = 1; end
        1:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 0; end
      endcase
      do_access(rd, wr, a, $urandom, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
